// File: rtl/capture_pkg.sv
// Shared types and constants for the pretrigger capture buffer.
// Frame header bytes are only emitted when CAPTURE_FRAME_HEADER_EN is defined.
package capture_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [7:0] HDR0 = 8'hA5;
    localparam logic [7:0] HDR1 = 8'h5A;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port memory: one write port, one read port with registered output.
module capture_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/pretrigger_capture_buffer.sv
// Circular pre/post-trigger sample recorder that drains one frame oldest-first over valid/ready.
// Build option: CAPTURE_FRAME_HEADER_EN prefixes every frame with two header bytes.
module pretrigger_capture_buffer
    import capture_pkg::*;
#(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int DEPTH             = 256,
    parameter int PRE_TRIGGER       = 64,
    parameter int POST_TRIGGER      = 192
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         axiiv,
    input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
    input  logic                         trigger,
    output logic                         axiov,
    output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
    input  logic                         axior,
    output logic                         busy,
    output logic                         capture_done,
    output logic                         dropped,
    output logic [1:0]                   state_o
);

    // Output handshake: a byte moves when axiov && axior; while axiov is high and
    // axior low, axiov and axiod hold their values.

    localparam int W         = SAMPLE_DATA_WIDTH;
    localparam int AW        = ptr_width(DEPTH);
    localparam int CAP_LEN   = PRE_TRIGGER + POST_TRIGGER;
`ifdef CAPTURE_FRAME_HEADER_EN
    localparam int HDR_LEN   = 2;
`else
    localparam int HDR_LEN   = 0;
`endif
    localparam int FRAME_LEN = CAP_LEN + HDR_LEN;
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam int FW        = $clog2(PRE_TRIGGER + 1);
    localparam int PW        = $clog2(POST_TRIGGER + 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [PW-1:0] post_q, post_d;
    logic [CW-1:0] issue_q, issue_d;
    logic [CW-1:0] acc_q, acc_d;
    logic          pend_q, pend_d;
    logic          out_v_q, out_v_d;
    logic [W-1:0]  out_d_q, out_d_d;
    logic          skid_v_q, skid_v_d;
    logic [W-1:0]  skid_d_q, skid_d_d;
    logic          dropped_q, dropped_d;
`ifdef CAPTURE_FRAME_HEADER_EN
    logic          pend_hdr_q, pend_hdr_d;
    logic [W-1:0]  pend_hb_q, pend_hb_d;
`endif

    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  ram_rdata;
    logic [W-1:0]  arr_data;
    logic          pop;
    logic          last;
    logic [1:0]    occupancy;
    logic          credit_ok;

    capture_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (axiid),
        .re_i    (rd_en),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

`ifdef CAPTURE_FRAME_HEADER_EN
    assign arr_data = pend_hdr_q ? pend_hb_q : ram_rdata;
`else
    assign arr_data = ram_rdata;
`endif

    assign pop       = out_v_q && axior;
    assign last      = pop && (acc_q == CW'(FRAME_LEN - 1));
    // Output register + skid + one read in flight: never more than two bytes owed.
    assign occupancy = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, pend_q};
    assign credit_ok = pop ? (occupancy <= 2'd2) : (occupancy <= 2'd1);

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        fill_d    = fill_q;
        post_d    = post_q;
        issue_d   = issue_q;
        acc_d     = acc_q;
        pend_d    = pend_q;
        out_v_d   = out_v_q;
        out_d_d   = out_d_q;
        skid_v_d  = skid_v_q;
        skid_d_d  = skid_d_q;
        dropped_d = dropped_q;
`ifdef CAPTURE_FRAME_HEADER_EN
        pend_hdr_d = pend_hdr_q;
        pend_hb_d  = pend_hb_q;
`endif
        wr_en     = 1'b0;
        rd_en     = 1'b0;

        case (state_q)
            FILL: begin
                if (axiiv) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    if (fill_q != FW'(PRE_TRIGGER)) begin
                        fill_d = fill_q + FW'(1);
                    end
                    if (fill_d == FW'(PRE_TRIGGER)) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (axiiv) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                end
                if (trigger) begin
                    rptr_d  = wptr_q - AW'(PRE_TRIGGER);
                    post_d  = axiiv ? PW'(1) : PW'(0);
                    issue_d = '0;
                    acc_d   = '0;
                    state_d = (post_d == PW'(POST_TRIGGER)) ? DRAIN : POST;
                end
            end
            POST: begin
                if (axiiv) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    post_d = post_q + PW'(1);
                    if (post_d == PW'(POST_TRIGGER)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (axiiv) begin
                    dropped_d = 1'b1;
                end
                pend_d = 1'b0;
                if ((issue_q != CW'(FRAME_LEN)) && credit_ok) begin
                    issue_d = issue_q + CW'(1);
                    pend_d  = 1'b1;
`ifdef CAPTURE_FRAME_HEADER_EN
                    if (issue_q < CW'(2)) begin
                        pend_hdr_d = 1'b1;
                        pend_hb_d  = (issue_q == '0) ? W'(HDR0) : W'(HDR1);
                    end else begin
                        pend_hdr_d = 1'b0;
                        rd_en      = 1'b1;
                        rptr_d     = rptr_q + AW'(1);
                    end
`else
                    rd_en  = 1'b1;
                    rptr_d = rptr_q + AW'(1);
`endif
                end
                if (pop) begin
                    acc_d = acc_q + CW'(1);
                    if (skid_v_q) begin
                        out_d_d  = skid_d_q;
                        skid_v_d = 1'b0;
                    end else begin
                        out_v_d = 1'b0;
                    end
                end
                if (pend_q) begin
                    if (!out_v_d) begin
                        out_v_d = 1'b1;
                        out_d_d = arr_data;
                    end else begin
                        skid_v_d = 1'b1;
                        skid_d_d = arr_data;
                    end
                end
                if (last) begin
                    state_d   = FILL;
                    fill_d    = '0;
                    dropped_d = 1'b0;
                    pend_d    = 1'b0;
                    out_v_d   = 1'b0;
                    out_d_d   = '0;
                    skid_v_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            wptr_q    <= '0;
            rptr_q    <= '0;
            fill_q    <= '0;
            post_q    <= '0;
            issue_q   <= '0;
            acc_q     <= '0;
            pend_q    <= 1'b0;
            out_v_q   <= 1'b0;
            out_d_q   <= '0;
            skid_v_q  <= 1'b0;
            skid_d_q  <= '0;
            dropped_q <= 1'b0;
`ifdef CAPTURE_FRAME_HEADER_EN
            pend_hdr_q <= 1'b0;
            pend_hb_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            fill_q    <= fill_d;
            post_q    <= post_d;
            issue_q   <= issue_d;
            acc_q     <= acc_d;
            pend_q    <= pend_d;
            out_v_q   <= out_v_d;
            out_d_q   <= out_d_d;
            skid_v_q  <= skid_v_d;
            skid_d_q  <= skid_d_d;
            dropped_q <= dropped_d;
`ifdef CAPTURE_FRAME_HEADER_EN
            pend_hdr_q <= pend_hdr_d;
            pend_hb_q  <= pend_hb_d;
`endif
        end
    end

    assign axiov        = out_v_q;
    assign axiod        = out_d_q;
    assign busy         = (state_q == POST) || (state_q == DRAIN);
    assign capture_done = last;
    assign dropped      = dropped_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pretrigger_capture_buffer.sv
// Directed bench for pretrigger_capture_buffer (DEPTH=16, PRE=4, POST=8).
module tb_pretrigger_capture_buffer;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int POST  = 8;
    localparam int LEN   = PRE + POST;

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;

    logic         clk = 1'b0;
    logic         rst;
    logic         axiiv;
    logic [W-1:0] axiid;
    logic         trigger;
    logic         axiov;
    logic [W-1:0] axiod;
    logic         axior;
    logic         busy;
    logic         capture_done;
    logic         dropped;
    logic [1:0]   state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    pretrigger_capture_buffer #(
        .SAMPLE_DATA_WIDTH (W),
        .DEPTH             (DEPTH),
        .PRE_TRIGGER       (PRE),
        .POST_TRIGGER      (POST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .axiiv        (axiiv),
        .axiid        (axiid),
        .trigger      (trigger),
        .axiov        (axiov),
        .axiod        (axiod),
        .axior        (axior),
        .busy         (busy),
        .capture_done (capture_done),
        .dropped      (dropped),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; axiiv = 1'b0; axiid = '0; trigger = 1'b0; axior = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic feed(input int v, input logic trig);
        axiiv = 1'b1; axiid = W'(v); trigger = trig; axior = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_window(input int first);
`ifdef CAPTURE_FRAME_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
`endif
        for (int i = 0; i < LEN; i++) exp_q.push_back(W'(first + i));
    endtask

    task automatic drain(input int max_cyc, input logic rand_ready, input logic feed_in,
                         input logic expect_done);
        int cyc = 0;
        int first_v = -1;
        int busy_low = 0;
        logic done = 1'b0;
        logic stalled = 1'b0;
        logic [W-1:0] stall_d = '0;
        logic [W-1:0] e;
        while (!done && cyc < max_cyc) begin
            axiiv = feed_in; axiid = 8'hEE;
            axior = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (busy !== 1'b1) busy_low++;
            if (stalled) begin
                check("stall_valid", 32'(axiov), 32'd1);
                check("stall_data", 32'(axiod), 32'(stall_d));
            end
            if (axiov && first_v < 0) first_v = cyc;
            if (axiov && axior) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(axiod), 32'(e));
                    check("done_pulse", 32'(capture_done), 32'(exp_q.size() == 0));
                    if (feed_in && exp_q.size() == 0) check("dropped_sticky", 32'(dropped), 32'd1);
                    if (exp_q.size() == 0) done = 1'b1;
                end
            end else if (capture_done) begin
                check("spurious_done", 32'(capture_done), 32'd0);
            end
            stalled = axiov && !axior;
            stall_d = axiod;
            @(posedge clk);
            #1;
            cyc++;
        end
        axiiv = 1'b0;
        if (expect_done) begin
            check("drain_complete", 32'(done), 32'd1);
            check("first_valid_latency", 32'(first_v >= 0 && first_v <= 2), 32'd1);
            check("busy_in_drain", 32'(busy_low), 32'd0);
            check("post_frame_axiov", 32'(axiov), 32'd0);
            check("post_frame_busy", 32'(busy), 32'd0);
            check("post_frame_state", 32'(state_o), 32'(S_FILL));
            check("post_frame_dropped", 32'(dropped), 32'd0);
        end
    endtask

    task automatic ramp_capture(input int trig_val, input int last_val);
        for (int v = 0; v <= last_val; v++) begin
            feed(v, v == trig_val);
            if (v == trig_val) check("busy_after_trigger", 32'(busy), 32'd1);
        end
        axiiv = 1'b0; trigger = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_axiov", 32'(axiov), 32'd0);
        check("rst_axiod", 32'(axiod), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(capture_done), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_state", 32'(state_o), 32'(S_FILL));

        // Basic ramp, trigger on 10 -> 6..17
        ramp_capture(10, 17);
        push_window(6);
        drain(100, 1'b0, 1'b0, 1'b1);

        // Early trigger ignored, held trigger fires once ARMED -> 0..11
        do_reset();
        feed(0, 1'b0);
        feed(1, 1'b0);
        feed(2, 1'b1);
        check("early_trig_ignored", 32'(state_o), 32'(S_FILL));
        feed(3, 1'b1);
        check("armed_after_fill", 32'(state_o), 32'(S_ARMED));
        feed(4, 1'b1);
        check("post_after_trigger", 32'(state_o), 32'(S_POST));
        for (int v = 5; v <= 11; v++) feed(v, 1'b1);
        push_window(0);
        drain(100, 1'b0, 1'b0, 1'b1);
        // Trigger still high: must refill PRE samples before firing again
        for (int v = 0; v < 3; v++) feed(100 + v, 1'b1);
        check("held_trig_no_refire", 32'(state_o), 32'(S_FILL));
        feed(103, 1'b1);
        check("held_trig_armed", 32'(state_o), 32'(S_ARMED));
        feed(104, 1'b1);
        check("held_trig_refire", 32'(state_o), 32'(S_POST));

        // Wrap-around: trigger on 29 (write index 13) -> 25..36
        do_reset();
        ramp_capture(29, 36);
        push_window(25);
        drain(100, 1'b0, 1'b0, 1'b1);

        // Random backpressure
        do_reset();
        ramp_capture(10, 17);
        push_window(6);
        drain(400, 1'b1, 1'b0, 1'b1);

        // Samples arriving during DRAIN are discarded and flagged
        do_reset();
        ramp_capture(10, 17);
        push_window(6);
        drain(100, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of DRAIN abandons the frame
        do_reset();
        ramp_capture(10, 17);
        push_window(6);
        drain(5, 1'b0, 1'b1, 1'b0);
        check("mid_drain_dropped", 32'(dropped), 32'd1);
        rst = 1'b1; axior = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_axiov", 32'(axiov), 32'd0);
        check("mid_rst_dropped", 32'(dropped), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'(S_FILL));
        check("mid_rst_busy", 32'(busy), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (axiov) seen++;
                @(posedge clk);
                #1;
            end
            check("no_resume_after_rst", 32'(seen), 32'd0);
        end
        ramp_capture(10, 17);
        push_window(6);
        drain(100, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pretrigger_capture_buffer.md
Name: pretrigger_capture_buffer

Overview:
- Sits between the ADC sample stream / minmax_filter trigger and the UART/SD sink consumed by filter_manager.
- Continuously records downsampled ADC samples into a circular buffer.
- On trigger, freezes a window of PRE_TRIGGER samples before the trigger plus POST_TRIGGER samples from the trigger onward.
- Drains that window oldest-first over a valid/ready byte stream.

Parameters:
- SAMPLE_DATA_WIDTH, 8: width of each sample and of the output data.
- DEPTH, 256: buffer entries. Must be a power of 2.
- PRE_TRIGGER, 64: samples kept from before the trigger. Must be ≥1.
- POST_TRIGGER, 192: samples kept from the trigger onward. Must be ≥1, and PRE_TRIGGER+POST_TRIGGER ≤ DEPTH.

Ports:
- clk  in  1  system clock (sys_clk domain).
- rst  in  1  synchronous, active-high reset.
- axiiv  in  1  input sample valid, single-cycle strobe.
- axiid  in  SAMPLE_DATA_WIDTH  input sample.
- trigger  in  1  level trigger from minmax_filter.
- axiov  out  1  output data valid.
- axiod  out  SAMPLE_DATA_WIDTH  output data.
- axior  in  1  downstream ready.
- busy  out  1  high in POST and DRAIN.
- capture_done  out  1  one-cycle pulse when the last byte of a frame is accepted.
- dropped  out  1  sticky flag: a sample arrived in DRAIN and was discarded. Cleared on entry to FILL.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset values: axiov=0, axiod=0, busy=0, capture_done=0, dropped=0; state=FILL; write pointer=0; fill count=0.
- Write pointer width is log2(DEPTH) and wraps modulo DEPTH.
- FILL:
  - Each axiiv writes axiid at the write pointer, advances the pointer, and increments the fill count (saturating at PRE_TRIGGER).
  - trigger is ignored.
  - Move to ARMED in the cycle the fill count reaches PRE_TRIGGER.
- ARMED:
  - Keep writing samples.
  - On trigger=1, latch start = wptr − PRE_TRIGGER (mod DEPTH), where wptr is the pointer value before any write in that cycle. Then go to POST.
  - If axiiv coincides with trigger, that sample is written and counts as post-trigger sample #1.
- POST:
  - Write samples and count post samples.
  - When the count reaches POST_TRIGGER, stop writing and go to DRAIN.
  - trigger is ignored.
- DRAIN:
  - Read CAPTURE_LEN = PRE_TRIGGER+POST_TRIGGER entries starting at start, with wrap-around, presenting them on axiod.
  - axiov/axiod must stay stable while axiov=1 and axior=0.
  - A transfer occurs when axiov and axior are both high.
  - The buffer is memory with 1-cycle read latency. The first axiov rises ≤2 cycles after entering DRAIN.
  - Back-to-back transfers at 1 byte/cycle are required when axior is held high.
  - Incoming samples are discarded and set dropped.
  - On the final transfer, pulse capture_done, drop axiov the next cycle, reset the fill count, and go to FILL.
- trigger held high across the end of DRAIN re-fires only after FILL completes again.
- Mid-operation reset: abandon the frame immediately. axiov falls in the cycle after rst is sampled; no partial frame resumes.
- busy = (state==POST || state==DRAIN).

Optional Feature:
- Macro CAPTURE_FRAME_HEADER_EN.
- Defined:
  - Each DRAIN begins with two header bytes, 8'hA5 then 8'h5A (zero-extended/truncated to SAMPLE_DATA_WIDTH), under the same handshake, before the samples.
  - Frame length = CAPTURE_LEN+2; capture_done pulses on the last sample.
- Undefined: no header; frame length = CAPTURE_LEN.

Decomposition:
- Package capture_pkg holds:
  - state enum {FILL, ARMED, POST, DRAIN};
  - header constants HDR0=8'hA5, HDR1=8'h5A;
  - a localparam function for pointer width.
- One sub-module: capture_ram, a simple dual-port inferred BRAM (write port, registered read port).
- The FSM, pointers and the output skid register stay in the top module.

Test Plan (DEPTH=16, PRE_TRIGGER=4, POST_TRIGGER=8, axior=1 unless stated):
- Ramp in 0,1,2,… every cycle; trigger at the sample valued 10 → output 6,7,8,9,10..17, then capture_done; busy high throughout.
- Trigger asserted while only 2 samples are stored → ignored. Trigger held until ARMED → window = first 4 samples plus 8 more.
- Wrap: feed 30 samples, trigger on value 29 with the write pointer at index 13 → output 25..36 read across index 15→0 correctly.
- Backpressure: toggle axior randomly 50% → same 12-byte sequence, no duplicates or skips, axiod stable while stalled.
- Feed samples during DRAIN → dropped=1 until re-entry to FILL. Assert rst mid-DRAIN → axiov=0 next cycle, dropped=0, state FILL.
- With CAPTURE_FRAME_HEADER_EN: first scenario yields A5,5A,6..17; capture_done on byte 17.
